// File: rtl/arb_mux_if.sv
// Channel bundle for arb_mux: N request lanes in, one registered beat out.
// The last_in lanes exist only when ARB_MUX_LOCK_EN is defined.
interface arb_mux_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
);
    logic [N-1:0]       valid_in;
    logic [N*WIDTH-1:0] data_in;
    logic [N-1:0]       ready_out;
    logic               valid_out;
    logic [WIDTH-1:0]   data_out;
    logic [SEL_W-1:0]   sel_out;
    logic               ready_in;
`ifdef ARB_MUX_LOCK_EN
    logic [N-1:0]       last_in;

    // master: requesters plus downstream sink; slave: the arbiter itself
    modport master (
        output valid_in, data_in, ready_in, last_in,
        input  ready_out, valid_out, data_out, sel_out
    );
    modport slave (
        input  valid_in, data_in, ready_in, last_in,
        output ready_out, valid_out, data_out, sel_out
    );
`else
    modport master (
        output valid_in, data_in, ready_in,
        input  ready_out, valid_out, data_out, sel_out
    );
    modport slave (
        input  valid_in, data_in, ready_in,
        output ready_out, valid_out, data_out, sel_out
    );
`endif
endinterface

// File: rtl/arb_mux.sv
// N-channel arbitrating mux (fixed priority or round-robin) feeding a one-deep
// valid/ready output register. Define ARB_MUX_LOCK_EN to enable burst locking.
module arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int RR    = 1,
    parameter int SEL_W = $clog2(N)
) (
    input  logic     clk_in,
    input  logic     rstn_in,
    arb_mux_if.slave bus
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_ptr;

    logic             w_space;
    logic [N-1:0]     w_grant;
    logic [SEL_W-1:0] w_gnt_idx;
    logic [N-1:0]     w_ready;
    logic [N-1:0]     w_take;
    logic             w_xfer;
    logic [SEL_W-1:0] w_next_ptr;

    // Reset is folded in so nothing is accepted while the block is held.
    assign w_space = rstn_in & (~r_valid | bus.ready_in);

`ifdef ARB_MUX_LOCK_EN
    typedef enum logic {S_IDLE, S_LOCKED} lock_state_t;

    lock_state_t      r_state;
    logic [SEL_W-1:0] r_owner;
    logic             w_last;

    assign w_last = |(w_take & bus.last_in);

    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            r_state <= S_IDLE;
            r_owner <= '0;
        end else if (w_xfer) begin
            if (w_last) begin
                r_state <= S_IDLE;
            end else begin
                r_state <= S_LOCKED;
                r_owner <= w_gnt_idx;
            end
        end
    end
`endif

    always_comb begin : arbitrate
        int   idx;
        logic found;
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        idx       = 0;
        found     = 1'b0;
        w_grant   = '0;
        w_gnt_idx = '0;
        for (int k = 0; k < N; k++) begin
            idx = (RR != 0) ? int'(r_ptr) + k : k;
            if (idx >= N) idx = idx - N;
            for (int i = 0; i < N; i++) begin
                if (!found && i == idx && bus.valid_in[i]) begin
                    found      = 1'b1;
                    w_grant[i] = 1'b1;
                    w_gnt_idx  = SEL_W'(i);
                end
            end
        end
`ifdef ARB_MUX_LOCK_EN
        // The owner keeps the grant even while its valid is low.
        if (r_state == S_LOCKED) begin
            w_grant   = '0;
            w_gnt_idx = r_owner;
            for (int i = 0; i < N; i++) begin
                if (SEL_W'(i) == r_owner) w_grant[i] = 1'b1;
            end
        end
`endif
    end

    assign w_ready    = w_grant & {N{w_space}};
    assign w_take     = bus.valid_in & w_ready;
    assign w_xfer     = |w_take;
    assign w_next_ptr = (w_gnt_idx == SEL_W'(N - 1)) ? '0 : w_gnt_idx + SEL_W'(1);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (!rstn_in) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_sel   <= w_gnt_idx;
            r_ptr   <= w_next_ptr;
            for (int i = 0; i < N; i++) begin
                if (w_take[i]) r_data <= bus.data_in[i*WIDTH +: WIDTH];
            end
        end else if (bus.ready_in) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.ready_out = w_ready;
    assign bus.valid_out = r_valid;
    assign bus.data_out  = r_data;
    assign bus.sel_out   = r_sel;
endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N-channel arbitrating multiplexer with a registered valid/ready output stage. It is the successor to the combinational select muxes in the datapath and is used where several requesters share one downstream port, such as I-fetch, D-access and debug sharing a memory bus. Selection is made internally by fixed-priority or round-robin arbitration rather than by an external select. A one-deep output register decouples the arbitration path from the downstream ready.

## Interface
- `WIDTH`, 32: data width per channel.
- `N`, 4: channel count, ≥2.
- `RR`, 1: 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- `SEL_W`, `$clog2(N)`: width of the grant index. Derived; do not override.

Ports:
- `clk_in`  in  1  clock. All state updates on the rising edge.
- `rstn_in`  in  1  reset. Synchronous, active-low.
- `valid_in`  in  N  per-channel request valid.
- `data_in`  in  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- `ready_out`  out  N  per-channel accept, one-hot or zero.
- `valid_out`  out  1  output register holds a beat.
- `data_out`  out  WIDTH  registered data.
- `sel_out`  out  SEL_W  index of the channel that supplied `data_out`.
- `ready_in`  in  1  downstream accept.
- `last_in`  in  N  per-channel end-of-burst. Present only with `ARB_MUX_LOCK_EN`.

## Operation
- `space = ~valid_out | ready_in`.
- Arbitration is combinational over `valid_in` and yields a one-hot `grant`.
- `ready_out = grant & {N{space}}`.
- A transfer on channel i occurs when `valid_in[i] & ready_out[i]`. On a transfer the register loads `data_out`, sets `sel_out = i` and sets `valid_out = 1`.
- If `valid_out & ready_in` and no new transfer occurs, `valid_out` clears next cycle. `data_out` and `sel_out` hold their last values.
- Fixed priority: the lowest set index of `valid_in` wins.
- Round-robin: pointer `ptr` (SEL_W bits) marks the highest-priority index. Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - After a transfer on i, `ptr` becomes (i+1) mod N. Wrap is modulo N, not 2^SEL_W, when N is not a power of two.
  - `ptr` changes only on a transfer.
- With no valid requests, or with `space = 0`, `ready_out = 0`. Arbiter state is unchanged.
- Upstream rule: a channel must hold `valid_in` and its data stable until accepted. The block does not depend on this for correctness, but the bench checks it.
- Downstream rule: while `valid_out & ~ready_in`, `data_out` and `sel_out` are stable.

## Timing
- Latency: 1 cycle from accept to `valid_out`.
- Throughput: 1 beat/cycle under continuous `ready_in`.
- Combinational paths: `ready_in` → `ready_out`, and `valid_in` → `ready_out`. There is no path from input data to output.
- Reset (`rstn_in = 0` at a clock edge) sets: `valid_out = 0`, `data_out = 0`, `sel_out = 0`, `ptr = 0`, lock cleared.
- While `rstn_in = 0`, `ready_out = 0`.
- A beat held in the register at reset is discarded.
- Simultaneous drain and load in one cycle keeps `valid_out = 1` and shows the new beat next cycle, with no bubble.

## Configuration
- Macro: `ARB_MUX_LOCK_EN`.
- Defined: adds the `last_in` port and the lock state machine.
  - States are IDLE and LOCKED(owner).
  - A transfer with `last_in[i] = 0` enters LOCKED with owner = i.
  - In LOCKED, only the owner may be granted, even if its `valid_in` drops.
  - A transfer on the owner with `last_in = 1` returns to IDLE, and `ptr` advances past the owner.
  - A single-beat transfer (`last_in = 1`) in IDLE stays in IDLE.
  - Reset returns to IDLE.
- Undefined: no `last_in` port; every beat is arbitrated independently.

## Test plan
- **Reset:** hold `rstn_in = 0` with all `valid_in = 1` → `ready_out = 0`, `valid_out = 0`, `data_out = 0` for each held cycle.
- **Round-robin fairness:** RR=1, N=4, `valid_in = 4'b1111` constant, `ready_in = 1` → `sel_out` sequence 0,1,2,3,0 on consecutive cycles, with `valid_out` continuously 1 from cycle 1.
- **Fixed priority:** RR=0, `valid_in = 4'b1010` → channel 1 granted every cycle and channel 3 never granted. Drop `valid_in[1]` → channel 3 granted next cycle.
- **Backpressure:** beat 0xA5A5A5A5 from ch2 accepted, then `ready_in = 0` for 3 cycles → `data_out` and `sel_out = 2` stable and `ready_out = 0` throughout. Raise `ready_in` → ch2 next beat loads the same cycle, with no bubble.
- **Non-power-of-two wrap:** N=3, RR=1, `valid_in = 3'b101` → grants alternate 0,2,0,2, and `ptr` never reaches 3.
- **Lock (`ARB_MUX_LOCK_EN`):** ch1 sends a 3-beat burst (`last_in` on beat 3) while ch0 and ch2 are valid → `sel_out` 1,1,1 then 2, and ch0 is not granted during the burst.
